// File: rtl/ibex_pkg.sv
// ============================================================================
// Module  : ibex_pkg
// Purpose : Shared types for the multiply/divide request-side controller.
//           md_op_e selects the unit operation; md_issue_state_e encodes the
//           issue controller FSM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MDI_IDLE  = 2'b00,
        MDI_ISSUE = 2'b01,
        MDI_DRAIN = 2'b10,
        MDI_WB    = 2'b11
    } md_issue_state_e;

    // True for operations executed by the multiplier half of the unit.
    function automatic logic md_is_mult(md_op_e op);
        return (op == MD_OP_MULL) || (op == MD_OP_MULH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_multdiv_result_cache.sv
// ============================================================================
// Module  : ibex_multdiv_result_cache
// Purpose : One-entry last-result cache for the multiply/divide unit.
//           Holds the tag (operator, signed mode, operands), the result and a
//           valid bit. Valid is cleared only by reset.
// Ports   : clk_i/rst_ni           clock, async active-low reset
//           we_i, wr_*_i           write port (tag + result)
//           lk_*_i                 lookup fields, compared combinationally
//           hit_o, result_o        lookup hit and cached result
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ibex_multdiv_result_cache
    import ibex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  md_op_e      wr_operator_i,
    input  logic [1:0]  wr_signed_mode_i,
    input  logic [31:0] wr_op_a_i,
    input  logic [31:0] wr_op_b_i,
    input  logic [31:0] wr_result_i,
    input  md_op_e      lk_operator_i,
    input  logic [1:0]  lk_signed_mode_i,
    input  logic [31:0] lk_op_a_i,
    input  logic [31:0] lk_op_b_i,
    output logic        hit_o,
    output logic [31:0] result_o
);

    logic        r_valid;
    md_op_e      r_operator;
    logic [1:0]  r_signed_mode;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_result;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid       <= 1'b0;
            r_operator    <= MD_OP_MULL;
            r_signed_mode <= 2'b00;
            r_op_a        <= 32'd0;
            r_op_b        <= 32'd0;
            r_result      <= 32'd0;
        end else if (we_i) begin
            r_valid       <= 1'b1;
            r_operator    <= wr_operator_i;
            r_signed_mode <= wr_signed_mode_i;
            r_op_a        <= wr_op_a_i;
            r_op_b        <= wr_op_b_i;
            r_result      <= wr_result_i;
        end
    end

    assign hit_o = r_valid
                && (r_operator    == lk_operator_i)
                && (r_signed_mode == lk_signed_mode_i)
                && (r_op_a        == lk_op_a_i)
                && (r_op_b        == lk_op_b_i);

    assign result_o = r_result;

endmodule

`default_nettype wire

// File: rtl/ibex_multdiv_issue.sv
// ============================================================================
// Module  : ibex_multdiv_issue
// Purpose : Request-side controller for the iterative mult/div unit. Accepts
//           one request at a time, holds enables and operands stable until
//           the unit reports valid, then presents the result to writeback
//           through a valid/ready handshake. Repeated identical operations
//           are served from a one-entry cache; a kill during execution is
//           drained because the unit cannot be aborted.
// Ports   : req_*      request from ID (valid/ready handshake)
//           kill_i     flush of the in-flight/pending operation
//           md_*, *_en unit interface (enables, latched operands, valid/result)
//           wb_*       result to writeback (valid/ready handshake)
//           busy_o     controller not idle
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ibex_multdiv_issue
    import ibex_pkg::*;
#(
    parameter bit ResultCache = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  md_op_e      req_operator_i,
    input  logic [1:0]  req_signed_mode_i,
    input  logic [31:0] req_op_a_i,
    input  logic [31:0] req_op_b_i,
    input  logic [4:0]  req_rd_i,
    input  logic        kill_i,

    output logic        mult_en_o,
    output logic        div_en_o,
    output md_op_e      md_operator_o,
    output logic [1:0]  md_signed_mode_o,
    output logic [31:0] md_op_a_o,
    output logic [31:0] md_op_b_o,
    output logic        md_ready_id_o,
    input  logic        md_valid_i,
    input  logic [31:0] md_result_i,

    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_result_o,

    output logic        busy_o
);

    md_issue_state_e r_state, w_state_next;

    md_op_e      r_operator;
    logic [1:0]  r_signed_mode;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [4:0]  r_rd;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_capture_unit;
    logic        w_capture_cache;
    logic        w_cache_we;
    logic        w_cache_hit;
    logic        w_hit;
    logic [31:0] w_cache_result;

    // The cache is looked up with the incoming request so a hit can skip the
    // unit entirely; it is written with the latched tag once the unit is done.
    ibex_multdiv_result_cache u_result_cache (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .we_i             (w_cache_we),
        .wr_operator_i    (r_operator),
        .wr_signed_mode_i (r_signed_mode),
        .wr_op_a_i        (r_op_a),
        .wr_op_b_i        (r_op_b),
        .wr_result_i      (md_result_i),
        .lk_operator_i    (req_operator_i),
        .lk_signed_mode_i (req_signed_mode_i),
        .lk_op_a_i        (req_op_a_i),
        .lk_op_b_i        (req_op_b_i),
        .hit_o            (w_cache_hit),
        .result_o         (w_cache_result)
    );

    assign w_hit = ResultCache && w_cache_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= MDI_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_accept        = 1'b0;
        w_capture_unit  = 1'b0;
        w_capture_cache = 1'b0;
        w_cache_we      = 1'b0;
        case (r_state)
            MDI_IDLE: begin
                // A request arriving together with kill is consumed and dropped.
                if (req_valid_i && !kill_i) begin
                    w_accept = 1'b1;
                    if (w_hit) begin
                        w_capture_cache = 1'b1;
                        w_state_next    = MDI_WB;
                    end else begin
                        w_state_next    = MDI_ISSUE;
                    end
                end
            end
            MDI_ISSUE: begin
                if (md_valid_i) begin
                    // A finished result is always correct, so it is cached even
                    // when the instruction itself is being flushed.
                    w_cache_we = 1'b1;
                    if (kill_i) begin
                        w_state_next = MDI_IDLE;
                    end else begin
                        w_capture_unit = 1'b1;
                        w_state_next   = MDI_WB;
                    end
                end else if (kill_i) begin
                    w_state_next = MDI_DRAIN;
                end
            end
            MDI_DRAIN: begin
                // The unit cannot be aborted: keep it running until it reports.
                if (md_valid_i) begin
                    w_cache_we   = 1'b1;
                    w_state_next = MDI_IDLE;
                end
            end
            MDI_WB: begin
                if (kill_i || wb_ready_i) begin
                    w_state_next = MDI_IDLE;
                end
            end
            default: w_state_next = MDI_IDLE;
        endcase
    end

    // Operand latch and result register. The latch only changes on accept in
    // IDLE, which keeps the unit operands constant through ISSUE and DRAIN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_operator    <= MD_OP_MULL;
            r_signed_mode <= 2'b00;
            r_op_a        <= 32'd0;
            r_op_b        <= 32'd0;
            r_rd          <= 5'd0;
            r_result      <= 32'd0;
        end else begin
            if (w_accept) begin
                r_operator    <= req_operator_i;
                r_signed_mode <= req_signed_mode_i;
                r_op_a        <= req_op_a_i;
                r_op_b        <= req_op_b_i;
                r_rd          <= req_rd_i;
            end
            if (w_capture_unit) begin
                r_result <= md_result_i;
            end else if (w_capture_cache) begin
                r_result <= w_cache_result;
            end
        end
    end

    logic w_unit_active;
    assign w_unit_active = (r_state == MDI_ISSUE) || (r_state == MDI_DRAIN);

    assign req_ready_o      = (r_state == MDI_IDLE);
    assign busy_o           = (r_state != MDI_IDLE);
    assign mult_en_o        = w_unit_active &&  md_is_mult(r_operator);
    assign div_en_o         = w_unit_active && !md_is_mult(r_operator);
    assign md_ready_id_o    = w_unit_active;
    assign md_operator_o    = r_operator;
    assign md_signed_mode_o = r_signed_mode;
    assign md_op_a_o        = r_op_a;
    assign md_op_b_o        = r_op_b;
    assign wb_valid_o       = (r_state == MDI_WB);
    assign wb_rd_o          = r_rd;
    assign wb_result_o      = r_result;

endmodule

`default_nettype wire

// File: tb/tb_ibex_multdiv_issue.sv
// ============================================================================
// Module  : tb_ibex_multdiv_issue
// Purpose : Self-checking bench for ibex_multdiv_issue with a fixed-latency
//           behavioural model of the iterative mult/div unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ibex_multdiv_issue;
    import ibex_pkg::*;

    localparam int c_LAT = 34;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    md_op_e      req_operator_i = MD_OP_MULL;
    logic [1:0]  req_signed_mode_i = 2'b00;
    logic [31:0] req_op_a_i = 32'd0;
    logic [31:0] req_op_b_i = 32'd0;
    logic [4:0]  req_rd_i = 5'd0;
    logic        kill_i = 1'b0;
    logic        mult_en_o, div_en_o, md_ready_id_o;
    md_op_e      md_operator_o;
    logic [1:0]  md_signed_mode_o;
    logic [31:0] md_op_a_o, md_op_b_o;
    logic        md_valid_i;
    logic [31:0] md_result_i;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_result_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ibex_multdiv_issue #(.ResultCache(1'b1)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_operator_i    (req_operator_i),
        .req_signed_mode_i (req_signed_mode_i),
        .req_op_a_i        (req_op_a_i),
        .req_op_b_i        (req_op_b_i),
        .req_rd_i          (req_rd_i),
        .kill_i            (kill_i),
        .mult_en_o         (mult_en_o),
        .div_en_o          (div_en_o),
        .md_operator_o     (md_operator_o),
        .md_signed_mode_o  (md_signed_mode_o),
        .md_op_a_o         (md_op_a_o),
        .md_op_b_o         (md_op_b_o),
        .md_ready_id_o     (md_ready_id_o),
        .md_valid_i        (md_valid_i),
        .md_result_i       (md_result_i),
        .wb_valid_o        (wb_valid_o),
        .wb_ready_i        (wb_ready_i),
        .wb_rd_o           (wb_rd_o),
        .wb_result_o       (wb_result_o),
        .busy_o            (busy_o)
    );

    // ---------------- unit model: fixed latency, RISC-V M semantics ----------
    function automatic logic [31:0] unit_calc(md_op_e op, logic [1:0] sm,
                                              logic [31:0] a, logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic signed [31:0] sa, sb;
        logic sgn;
        ea  = sm[0] ? {{32{a[31]}}, a} : {32'd0, a};
        eb  = sm[1] ? {{32{b[31]}}, b} : {32'd0, b};
        p   = ea * eb;
        sa  = a;
        sb  = b;
        sgn = (sm == 2'b11);
        case (op)
            MD_OP_MULL: return p[31:0];
            MD_OP_MULH: return p[63:32];
            MD_OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sgn ? 32'(sa / sb) : (a / b);
            end
            default: begin
                if (b == 32'd0) return a;
                if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sgn ? 32'(sa % sb) : (a % b);
            end
        endcase
    endfunction

    int unsigned unit_cnt;
    logic        unit_en;
    assign unit_en     = mult_en_o | div_en_o;
    assign md_valid_i  = unit_en && (unit_cnt == c_LAT - 1);
    assign md_result_i = unit_calc(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni)        unit_cnt <= 0;
        else if (md_valid_i) unit_cnt <= 0;
        else if (unit_en)   unit_cnt <= unit_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request and wait for its writeback. Returns the number of
    // cycles enables were high, cycles from accept to wb_valid, the result,
    // the rd, md_op_a_o one cycle after accept, and whether req_ready_o was
    // seen high while the controller should be busy.
    task automatic run_req(input md_op_e op, input logic [1:0] sm,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input bit do_wb,
                           output int en_cyc, output int lat,
                           output logic [31:0] res, output logic [4:0] rdo,
                           output logic [31:0] a_seen, output bit ready_leak,
                           output bit timeout);
        int guard;
        en_cyc = 0; lat = 1; ready_leak = 0; timeout = 0;
        guard = 0;
        while (!req_ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        req_valid_i       = 1'b1;
        req_operator_i    = op;
        req_signed_mode_i = sm;
        req_op_a_i        = a;
        req_op_b_i        = b;
        req_rd_i          = rd;
        @(negedge clk);
        req_valid_i = 1'b0;
        a_seen      = md_op_a_o;
        guard       = 0;
        while (!wb_valid_o && guard < 200) begin
            if (mult_en_o | div_en_o) en_cyc++;
            if (req_ready_o) ready_leak = 1;
            lat++;
            guard++;
            @(negedge clk);
        end
        timeout = !wb_valid_o;
        res = wb_result_o;
        rdo = wb_rd_o;
        if (do_wb) begin
            wb_ready_i = 1'b1;
            @(negedge clk);
            wb_ready_i = 1'b0;
        end
    endtask

    typedef struct {
        md_op_e      op;
        logic [1:0]  sm;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          exp_en;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int en_cyc, lat, guard;
        logic [31:0] res, a_seen;
        logic [4:0]  rdo;
        bit leak, tmo, bad;
        logic [31:0] hold_a, hold_b;
        logic [1:0]  hold_en;

        // MULL 7*6; signed DIV overflow, then identical hit; REM miss; MULH
        // signed and unsigned (signed_mode differs -> miss); DIV by zero.
        vecs[0] = '{MD_OP_MULL, 2'b00, 32'd7,          32'd6,          5'd5,  32'd42,         c_LAT};
        vecs[1] = '{MD_OP_DIV,  2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  5'd3,  32'h8000_0000,  c_LAT};
        vecs[2] = '{MD_OP_DIV,  2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  5'd4,  32'h8000_0000,  0};
        vecs[3] = '{MD_OP_REM,  2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  5'd6,  32'd0,          c_LAT};
        vecs[4] = '{MD_OP_MULH, 2'b11, 32'hFFFF_FFFF,  32'd2,          5'd10, 32'hFFFF_FFFF,  c_LAT};
        vecs[5] = '{MD_OP_MULH, 2'b00, 32'hFFFF_FFFF,  32'd2,          5'd11, 32'd1,          c_LAT};
        vecs[6] = '{MD_OP_DIV,  2'b00, 32'd100,        32'd0,          5'd12, 32'hFFFF_FFFF,  c_LAT};

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_busy",      {31'd0, busy_o},      32'd0);
        chk("rst_enables",   {30'd0, mult_en_o, div_en_o}, 32'd0);
        chk("rst_wb",        {26'd0, wb_valid_o, wb_rd_o}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);

        // ---------------- table-driven requests ----------------
        for (int i = 0; i < 7; i++) begin
            run_req(vecs[i].op, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b1,
                    en_cyc, lat, res, rdo, a_seen, leak, tmo);
            chk($sformatf("v%0d_timeout", i), {31'd0, tmo}, 32'd0);
            chk($sformatf("v%0d_result", i), res, vecs[i].exp);
            chk($sformatf("v%0d_rd", i), {27'd0, rdo}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d_en_cycles", i), en_cyc, vecs[i].exp_en);
            chk($sformatf("v%0d_latency", i), lat, (vecs[i].exp_en == 0) ? 1 : c_LAT + 1);
            chk($sformatf("v%0d_opa_latched", i), a_seen, vecs[i].a);
            chk($sformatf("v%0d_ready_low", i), {31'd0, leak}, 32'd0);
            chk($sformatf("v%0d_idle_after_wb", i), {30'd0, busy_o, req_ready_o}, 32'd1);
        end

        // ---------------- kill during DIV 100/7 ----------------
        req_valid_i = 1'b1; req_operator_i = MD_OP_DIV; req_signed_mode_i = 2'b00;
        req_op_a_i = 32'd100; req_op_b_i = 32'd7; req_rd_i = 5'd9;
        @(negedge clk);
        req_valid_i = 1'b0;
        hold_a  = md_op_a_o;
        hold_b  = md_op_b_o;
        hold_en = {mult_en_o, div_en_o};
        chk("kill_en_start", {30'd0, hold_en}, 32'd1);
        repeat (5) @(negedge clk);
        kill_i = 1'b1;             // held through DRAIN, where it is ignored
        bad = 0; guard = 0;
        while (!md_valid_i && guard < 200) begin
            @(negedge clk);
            if (guard == 2) kill_i = 1'b0;
            if (md_op_a_o !== hold_a || md_op_b_o !== hold_b ||
                {mult_en_o, div_en_o} !== hold_en || wb_valid_o || req_ready_o ||
                !md_ready_id_o || md_operator_o !== MD_OP_DIV)
                bad = 1;
            guard++;
        end
        kill_i = 1'b0;
        chk("kill_md_valid_seen", {31'd0, md_valid_i}, 32'd1);
        chk("kill_held_stable", {31'd0, bad}, 32'd0);
        @(negedge clk);
        chk("kill_ready_back", {30'd0, req_ready_o, wb_valid_o}, 32'd2);
        run_req(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 5'd13, 1'b1, en_cyc, lat, res, rdo, a_seen, leak, tmo);
        chk("kill_hit_result", res, 32'd14);
        chk("kill_hit_latency", lat, 1);
        chk("kill_hit_no_en", en_cyc, 0);

        // ---------------- WB hold, then kill with wb_ready ----------------
        run_req(MD_OP_MULL, 2'b00, 32'd3, 32'd5, 5'd7, 1'b0, en_cyc, lat, res, rdo, a_seen, leak, tmo);
        chk("hold_result", res, 32'd15);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!wb_valid_o || wb_result_o !== 32'd15 || wb_rd_o !== 5'd7) bad = 1;
        end
        chk("hold_stable", {31'd0, bad}, 32'd0);
        kill_i = 1'b1; wb_ready_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0; wb_ready_i = 1'b0;
        chk("hold_kill_drop", {30'd0, wb_valid_o, busy_o}, 32'd0);
        run_req(MD_OP_MULL, 2'b00, 32'd3, 32'd5, 5'd8, 1'b1, en_cyc, lat, res, rdo, a_seen, leak, tmo);
        chk("hold_cache_kept_lat", lat, 1);
        chk("hold_cache_kept_res", res, 32'd15);

        // ---------------- asynchronous reset during ISSUE ----------------
        req_valid_i = 1'b1; req_operator_i = MD_OP_MULL; req_signed_mode_i = 2'b00;
        req_op_a_i = 32'd9; req_op_b_i = 32'd9; req_rd_i = 5'd1;
        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_busy_before", {31'd0, busy_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_ctrl", {26'd0, req_ready_o, busy_o, mult_en_o, div_en_o, md_ready_id_o, wb_valid_o}, 32'h20);
        chk("rst_mid_md", {md_op_a_o[29:0], md_operator_o}, 32'd0);
        chk("rst_mid_md_b", md_op_b_o, 32'd0);
        chk("rst_mid_wb", wb_result_o, 32'd0);
        chk("rst_mid_rd", {25'd0, md_signed_mode_o, wb_rd_o}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        run_req(MD_OP_MULL, 2'b00, 32'd3, 32'd5, 5'd2, 1'b1, en_cyc, lat, res, rdo, a_seen, leak, tmo);
        chk("rst_cache_miss_en", en_cyc, c_LAT);
        chk("rst_cache_miss_res", res, 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
